// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM read port among NUM_REQ draw engines.
// Optional macro SPRITE_ARB_PRI0_EN gives requester 0 absolute priority over the ring.
module sprite_rom_arbiter #(
    parameter int                NUM_REQ   = 4,
    parameter int                ADDR_W    = 18,
    parameter int                DATA_W    = 12,
    parameter int                ROM_DEPTH = 61952,
    parameter int                ROM_LAT   = 0,
    parameter logic [DATA_W-1:0] KEY_COLOR = 12'h808,
    localparam int               ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_color,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_color,
    output logic                      rsp_opaque
);

    localparam logic [ID_W:0]       NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0]     LAST_IDX  = ID_W'(NUM_REQ - 1);
    localparam logic [ADDR_W:0]     DEPTH_W   = (ADDR_W+1)'(ROM_DEPTH);
    localparam logic [NUM_REQ-1:0]  GNT0      = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [ID_W-1:0]   ptr_r;
    logic [ID_W:0]     sum_s;
    logic [ID_W-1:0]   cand_s;
    logic              win_vld_s;
    logic [ID_W-1:0]   win_idx_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic              win_oob_s;
    logic              ptr_upd_s;
    logic [ID_W-1:0]   ptr_nxt_s;

    // Pipeline slot 0 is the issue stage; slots 1..ROM_LAT track the ROM's own delay.
    logic              pipe_vld_r [0:ROM_LAT];
    logic [ID_W-1:0]   pipe_id_r  [0:ROM_LAT];
    logic              pipe_oob_r [0:ROM_LAT];

    // Winner search: scan from ptr_r, wrapping, first asserted request wins.
    always_comb begin
        win_vld_s = 1'b0;
        win_idx_s = '0;
        sum_s     = '0;
        cand_s    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            sum_s     = {1'b0, ptr_r} + (ID_W+1)'(j);
            cand_s    = (sum_s >= NUM_REQ_W) ? ID_W'(sum_s - NUM_REQ_W) : ID_W'(sum_s);
            win_idx_s = (!win_vld_s && req[cand_s]) ? cand_s : win_idx_s;
            win_vld_s = win_vld_s | req[cand_s];
        end
`ifdef SPRITE_ARB_PRI0_EN
        win_idx_s = req[0] ? '0 : win_idx_s;
        win_vld_s = win_vld_s | req[0];
`endif
    end

    // Grant decode, range check and next-pointer computation.
    always_comb begin
        win_addr_s = req_addr[win_idx_s*ADDR_W +: ADDR_W];
        win_oob_s  = ({1'b0, win_addr_s} >= DEPTH_W);
        ptr_nxt_s  = (win_idx_s == LAST_IDX) ? '0 : win_idx_s + 1'b1;
`ifdef SPRITE_ARB_PRI0_EN
        // Requester 0 wins outside the ring, so it must not disturb the pointer.
        ptr_upd_s  = win_vld_s && (win_idx_s != '0);
`else
        ptr_upd_s  = win_vld_s;
`endif
        gnt        = (win_vld_s && Reset_n) ? (GNT0 << win_idx_s) : '0;
    end

    // Round-robin pointer and registered ROM address.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_r    <= '0;
            rom_addr <= '0;
        end else begin
            if (ptr_upd_s) begin
                ptr_r <= ptr_nxt_s;
            end
            if (win_vld_s) begin
                rom_addr <= win_oob_s ? '0 : win_addr_s;
            end
        end
    end

    // Valid/id/oob tags travelling alongside the ROM read.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i <= ROM_LAT; i++) begin
                pipe_vld_r[i] <= 1'b0;
                pipe_id_r[i]  <= '0;
                pipe_oob_r[i] <= 1'b0;
            end
        end else begin
            pipe_vld_r[0] <= win_vld_s;
            pipe_id_r[0]  <= win_idx_s;
            pipe_oob_r[0] <= win_oob_s;
            for (int i = 1; i <= ROM_LAT; i++) begin
                pipe_vld_r[i] <= pipe_vld_r[i-1];
                pipe_id_r[i]  <= pipe_id_r[i-1];
                pipe_oob_r[i] <= pipe_oob_r[i-1];
            end
        end
    end

    // Response register; payload holds between strobes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_color  <= '0;
            rsp_opaque <= 1'b0;
        end else begin
            rsp_valid <= pipe_vld_r[ROM_LAT];
            if (pipe_vld_r[ROM_LAT]) begin
                rsp_id     <= pipe_id_r[ROM_LAT];
                rsp_color  <= pipe_oob_r[ROM_LAT] ? KEY_COLOR : rom_color;
                rsp_opaque <= !pipe_oob_r[ROM_LAT] && (rom_color != KEY_COLOR);
            end
        end
    end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed vector table, corner sequences, random run.
module tb_sprite_rom_arbiter;

`ifdef SPRITE_ARB_PRI0_EN
    localparam bit PRI0 = 1'b1;
`else
    localparam bit PRI0 = 1'b0;
`endif
    localparam int          DEPTH = 61952;
    localparam logic [11:0] KEY   = 12'h808;

    logic        clk      = 1'b0;
    logic        Reset_n  = 1'b1;
    logic [3:0]  req      = 4'b0000;
    logic [71:0] req_addr = 72'd0;
    logic [3:0]  gnt;
    logic [17:0] rom_addr;
    logic [11:0] rom_color;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [11:0] rsp_color;
    logic        rsp_opaque;

    logic [3:0]  req2      = 4'b0000;
    logic [71:0] req_addr2 = 72'd0;
    logic [3:0]  gnt2;
    logic [17:0] rom_addr2;
    logic [11:0] rom_color2;
    logic        rsp_valid2;
    logic [1:0]  rsp_id2;
    logic [11:0] rsp_color2;
    logic        rsp_opaque2;
    logic [11:0] rom2_d1, rom2_d2;

    always #5 clk = ~clk;

    function automatic logic [11:0] romf(input logic [17:0] a);
        if (a == 18'h00100) return 12'h940;
        if (a == 18'h00200) return 12'h808;
        return a[11:0] ^ a[17:6] ^ 12'h5A3;
    endfunction

    function automatic logic [71:0] pk(input logic [17:0] a0, input logic [17:0] a1,
                                       input logic [17:0] a2, input logic [17:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    assign rom_color = romf(rom_addr);

    always @(posedge clk) begin
        rom2_d1 <= romf(rom_addr2);
        rom2_d2 <= rom2_d1;
    end
    assign rom_color2 = rom2_d2;

    sprite_rom_arbiter dut (
        .Clk(clk), .Reset_n(Reset_n), .req(req), .req_addr(req_addr), .gnt(gnt),
        .rom_addr(rom_addr), .rom_color(rom_color), .rsp_valid(rsp_valid),
        .rsp_id(rsp_id), .rsp_color(rsp_color), .rsp_opaque(rsp_opaque)
    );

    sprite_rom_arbiter #(.ROM_LAT(2)) dut2 (
        .Clk(clk), .Reset_n(Reset_n), .req(req2), .req_addr(req_addr2), .gnt(gnt2),
        .rom_addr(rom_addr2), .rom_color(rom_color2), .rsp_valid(rsp_valid2),
        .rsp_id(rsp_id2), .rsp_color(rsp_color2), .rsp_opaque(rsp_opaque2)
    );

    // Reference model state
    typedef struct {
        int          due;
        int          id;
        logic [11:0] color;
        bit          opq;
    } rsp_t;
    rsp_t        exp_q[$];
    int          m_ptr;
    int          cyc;
    logic [17:0] exp_rom_addr;
    int          last_id;
    logic [11:0] last_color;
    bit          last_opq;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_winner(input logic [3:0] r);
        if (PRI0 && r[0]) return 0;
        for (int j = 0; j < 4; j++) begin
            int i = (m_ptr + j) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ptr        = 0;
        exp_rom_addr = 18'd0;
        last_id      = 0;
        last_color   = 12'd0;
        last_opq     = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},        32'(gnt),         32'd0);
        chk({tag, "_rom_addr"},   32'(rom_addr),    32'd0);
        chk({tag, "_rsp_valid"},  32'(rsp_valid),   32'd0);
        chk({tag, "_rsp_id"},     32'(rsp_id),      32'd0);
        chk({tag, "_rsp_color"},  32'(rsp_color),   32'd0);
        chk({tag, "_rsp_opaque"}, 32'(rsp_opaque),  32'd0);
        chk({tag, "_rsp_valid2"}, 32'(rsp_valid2),  32'd0);
        chk({tag, "_rom_addr2"},  32'(rom_addr2),   32'd0);
    endtask

    task automatic reset_pulse(input string tag);
        Reset_n = 1'b0;
        #1;
        chk_zero(tag);
        model_reset();
        req  = 4'b0000;
        req2 = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        Reset_n = 1'b1;
    endtask

    // One clock of the main DUT: drive, check grant, advance, check ROM address and response.
    task automatic cycle(input logic [3:0] r, input logic [71:0] a, output int won, output logic [3:0] g);
        int          w;
        logic [17:0] ad;
        bit          oob;
        rsp_t        e;
        req      = r;
        req_addr = a;
        #1;
        g = gnt;
        w = model_winner(r);
        chk("gnt", 32'(gnt), (w >= 0) ? 32'(4'b0001 << w) : 32'd0);
        if (w >= 0) begin
            ad      = a[w*18 +: 18];
            oob     = (int'(ad) >= DEPTH);
            e.due   = cyc + 1;
            e.id    = w;
            e.color = oob ? KEY : romf(ad);
            e.opq   = !oob && (romf(ad) != KEY);
            exp_q.push_back(e);
            if (!(PRI0 && w == 0)) m_ptr = (w + 1) % 4;
        end
        @(posedge clk);
        if (w >= 0) exp_rom_addr = oob ? 18'd0 : ad;
        @(negedge clk);
        chk("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e          = exp_q.pop_front();
            last_id    = e.id;
            last_color = e.color;
            last_opq   = e.opq;
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
        end else begin
            chk("rsp_valid", 32'(rsp_valid), 32'd0);
        end
        chk("rsp_id",     32'(rsp_id),     32'(last_id));
        chk("rsp_color",  32'(rsp_color),  32'(last_color));
        chk("rsp_opaque", 32'(rsp_opaque), 32'(last_opq));
        cyc++;
        won = w;
    endtask

    function automatic logic [17:0] raddr();
        case ($urandom_range(0, 7))
            0:       return 18'd61951;
            1:       return 18'd61952;
            2:       return 18'h00200;
            3:       return 18'h3FFFF;
            default: return 18'($urandom_range(0, 70000));
        endcase
    endfunction

    typedef struct {
        bit          rst;
        logic [3:0]  req;
        logic [71:0] addr;
        logic [3:0]  gnt;
    } vec_t;

    initial begin
        vec_t        tbl[$];
        int          w;
        logic [3:0]  g;
        int          found;
        int          pulses;
        logic [1:0]  id2;
        logic [11:0] col2;
        logic        op2;

        cyc = 0;
        model_reset();
        #2;
        reset_pulse("init");

        // Single request, then idle to let the response out
        tbl.push_back('{1'b1, 4'b0010, pk(18'd0, 18'h00100, 18'd0, 18'd0), 4'b0010});
        tbl.push_back('{1'b0, 4'b0000, 72'd0, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 72'd0, 4'b0000});
        // Full contention from a fresh pointer
        for (int k = 0; k < 8; k++)
            tbl.push_back('{k == 0, 4'b1111, pk(18'h00010, 18'h00020, 18'h00030, 18'h00040),
                            PRI0 ? 4'b0001 : (4'b0001 << (k % 4))});
        tbl.push_back('{1'b0, 4'b0000, 72'd0, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 72'd0, 4'b0000});
        // Key colour and range boundaries
        tbl.push_back('{1'b1, 4'b0001, pk(18'h00200, 18'd0, 18'd0, 18'd0), 4'b0001});
        tbl.push_back('{1'b0, 4'b0001, pk(18'd61951, 18'd0, 18'd0, 18'd0), 4'b0001});
        tbl.push_back('{1'b0, 4'b0001, pk(18'd61952, 18'd0, 18'd0, 18'd0), 4'b0001});
        tbl.push_back('{1'b0, 4'b0000, 72'd0, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 72'd0, 4'b0000});
        // Pointer wrap from index 3
        tbl.push_back('{1'b1, 4'b1000, pk(18'd0, 18'd0, 18'd0, 18'h00333), 4'b1000});
        tbl.push_back('{1'b0, 4'b1001, pk(18'h00111, 18'd0, 18'd0, 18'h00333), 4'b0001});
        tbl.push_back('{1'b0, 4'b1001, pk(18'h00111, 18'd0, 18'd0, 18'h00333), PRI0 ? 4'b0001 : 4'b1000});
        tbl.push_back('{1'b0, 4'b0000, 72'd0, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 72'd0, 4'b0000});

        foreach (tbl[i]) begin
            if (tbl[i].rst) reset_pulse("tbl_rst");
            cycle(tbl[i].req, tbl[i].addr, w, g);
            chk($sformatf("tbl_gnt[%0d]", i), 32'(g), 32'(tbl[i].gnt));
        end

        // Reset while two reads are in flight
        reset_pulse("pre_mid");
        cycle(4'b0001, pk(18'h01234, 18'd0, 18'd0, 18'd0), w, g);
        req      = 4'b0010;
        req_addr = pk(18'd0, 18'h02345, 18'd0, 18'd0);
        #1;
        chk("mid_gnt", 32'(gnt), 32'(4'b0010));
        reset_pulse("mid");
        for (int k = 0; k < 4; k++) cycle(4'b0000, 72'd0, w, g);
        cycle(4'b1010, pk(18'd0, 18'h00055, 18'd0, 18'h00077), w, g);
        chk("post_rst_gnt", 32'(g), 32'(4'b0010));
        for (int k = 0; k < 3; k++) cycle(4'b0000, 72'd0, w, g);

        // Latency-2 instance: one request, bounded wait for its response
        reset_pulse("lat2");
        req2      = 4'b0100;
        req_addr2 = pk(18'd0, 18'd0, 18'h00345, 18'd0);
        #1;
        chk("lat2_gnt", 32'(gnt2), 32'(4'b0100));
        cycle(4'b0000, 72'd0, w, g);
        req2   = 4'b0000;
        found  = 0;
        pulses = 0;
        id2    = 2'd0;
        col2   = 12'd0;
        op2    = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cycle(4'b0000, 72'd0, w, g);
            if (rsp_valid2 === 1'b1) begin
                pulses++;
                if (found == 0) begin
                    found = k;
                    id2   = rsp_id2;
                    col2  = rsp_color2;
                    op2   = rsp_opaque2;
                end
            end
        end
        chk("lat2_delay",  32'(found),  32'd3);
        chk("lat2_pulses", 32'(pulses), 32'd1);
        chk("lat2_id",     32'(id2),    32'd2);
        chk("lat2_color",  32'(col2),   32'(romf(18'h00345)));
        chk("lat2_opaque", 32'(op2),    32'(romf(18'h00345) != KEY));

        // Randomised traffic with occasional resets
        reset_pulse("rand");
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 49) == 0) reset_pulse("rand_rst");
            cycle(4'($urandom_range(0, 15)), pk(raddr(), raddr(), raddr(), raddr()), w, g);
        end
        for (int k = 0; k < 4; k++) cycle(4'b0000, 72'd0, w, g);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
